// File: rtl/top_row_addr_gen.sv
// -----------------------------------------------------------------------------
// top_row_addr_gen
// Row-major address sequencer feeding the 15x5-bit row-offset multiplier.
// For each row the latched stride and the current row index are presented to
// the external multiplier; its product plus the base address becomes the row
// start address. One address per column is then emitted over a valid/ack
// handshake. Control uses the HLS block protocol (ap_start/ap_done/ap_idle).
//
// Ports:
//   ap_clk, ap_rst      clock, synchronous active-high reset
//   ap_start            start request, sampled only while idle
//   ap_done, ap_idle    one-cycle completion pulse, idle flag
//   stride/rows/cols/base  job parameters, latched at start
//   mul_din0, mul_din1  multiplier operands (stride, row index), from registers
//   mul_dout            multiplier product, combinational, 16-bit truncated
//   addr_out, addr_vld  generated address and its valid flag
//   addr_ack            consumer accepts addr_out this cycle
// -----------------------------------------------------------------------------
module top_row_addr_gen #(
    parameter int STRIDE_W = 15,
    parameter int ROW_W    = 5,
    parameter int ADDR_W   = 16
) (
    input  logic                ap_clk,
    input  logic                ap_rst,
    input  logic                ap_start,
    output logic                ap_done,
    output logic                ap_idle,
    input  logic [STRIDE_W-1:0] stride,
    input  logic [ROW_W-1:0]    rows,
    input  logic [STRIDE_W-1:0] cols,
    input  logic [ADDR_W-1:0]   base,
    output logic [STRIDE_W-1:0] mul_din0,
    output logic [ROW_W-1:0]    mul_din1,
    input  logic [ADDR_W-1:0]   mul_dout,
    output logic [ADDR_W-1:0]   addr_out,
    output logic                addr_vld,
    input  logic                addr_ack
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ROW  = 2'd1,
        S_EMIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_r;
    logic [STRIDE_W-1:0] stride_r;
    logic [ROW_W-1:0]    rows_r;
    logic [STRIDE_W-1:0] cols_r;
    logic [ADDR_W-1:0]   base_r;
    logic [ROW_W-1:0]    row_r;
    logic [STRIDE_W-1:0] col_r;
    logic [ADDR_W-1:0]   addr_out_r;
    logic                addr_vld_r;
    logic                ap_done_r;
    logic                ap_idle_r;

    // Multiplier operands come straight from the job registers in every state.
    assign mul_din0 = stride_r;
    assign mul_din1 = row_r;

    assign addr_out = addr_out_r;
    assign addr_vld = addr_vld_r;
    assign ap_done  = ap_done_r;
    assign ap_idle  = ap_idle_r;

    // Job FSM with registered handshake and control outputs.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_r    <= S_IDLE;
            stride_r   <= STRIDE_W'(0);
            rows_r     <= ROW_W'(0);
            cols_r     <= STRIDE_W'(0);
            base_r     <= ADDR_W'(0);
            row_r      <= ROW_W'(0);
            col_r      <= STRIDE_W'(0);
            addr_out_r <= ADDR_W'(0);
            addr_vld_r <= 1'b0;
            ap_done_r  <= 1'b0;
            ap_idle_r  <= 1'b1;
        end else begin
            case (state_r)
                S_IDLE: begin
                    ap_done_r <= 1'b0;
                    if (ap_start) begin
                        stride_r  <= stride;
                        rows_r    <= rows;
                        cols_r    <= cols;
                        base_r    <= base;
                        row_r     <= ROW_W'(0);
                        col_r     <= STRIDE_W'(0);
                        ap_idle_r <= 1'b0;
                        // An empty job finishes without ever touching the multiplier.
                        if ((rows == ROW_W'(0)) || (cols == STRIDE_W'(0))) begin
                            state_r   <= S_DONE;
                            ap_done_r <= 1'b1;
                        end else begin
                            state_r <= S_ROW;
                        end
                    end else begin
                        ap_idle_r <= 1'b1;
                    end
                end

                S_ROW: begin
                    // addr_out_r doubles as the running row_base + col value:
                    // loaded with the row start here, then stepped by one per
                    // accepted column, so it only ever changes on an accept.
                    addr_out_r <= base_r + mul_dout;
                    col_r      <= STRIDE_W'(0);
                    addr_vld_r <= 1'b1;
                    state_r    <= S_EMIT;
                end

                S_EMIT: begin
                    if (addr_ack) begin
                        if (col_r != (cols_r - STRIDE_W'(1))) begin
                            col_r      <= col_r + STRIDE_W'(1);
                            addr_out_r <= addr_out_r + ADDR_W'(1);
                        end else begin
                            addr_vld_r <= 1'b0;
                            addr_out_r <= ADDR_W'(0);
                            if (row_r != (rows_r - ROW_W'(1))) begin
                                row_r   <= row_r + ROW_W'(1);
                                state_r <= S_ROW;
                            end else begin
                                ap_done_r <= 1'b1;
                                state_r   <= S_DONE;
                            end
                        end
                    end else begin
                        state_r <= S_EMIT;
                    end
                end

                S_DONE: begin
                    ap_done_r <= 1'b0;
                    ap_idle_r <= 1'b1;
                    state_r   <= S_IDLE;
                end

                default: begin
                    state_r    <= S_IDLE;
                    addr_vld_r <= 1'b0;
                    ap_done_r  <= 1'b0;
                    ap_idle_r  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_top_row_addr_gen.sv
module tb_top_row_addr_gen;
    localparam int SW  = 15;
    localparam int RW  = 5;
    localparam int AW  = 16;
    localparam int BIG = 32'h4000_0000;

    logic          ap_clk = 1'b0;
    logic          ap_rst = 1'b1;
    logic          ap_start = 1'b0;
    logic          ap_done;
    logic          ap_idle;
    logic [SW-1:0] stride = '0;
    logic [RW-1:0] rows = '0;
    logic [SW-1:0] cols = '0;
    logic [AW-1:0] base = '0;
    logic [SW-1:0] mul_din0;
    logic [RW-1:0] mul_din1;
    logic [AW-1:0] mul_dout;
    logic [AW-1:0] addr_out;
    logic          addr_vld;
    logic          addr_ack;

    // Behavioural stand-in for the 15x5 multiplier: full product truncated to 16 bits.
    logic [19:0] prod;
    assign prod     = {5'd0, mul_din0} * {15'd0, mul_din1};
    assign mul_dout = prod[15:0];

    top_row_addr_gen dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
        .ap_done(ap_done), .ap_idle(ap_idle),
        .stride(stride), .rows(rows), .cols(cols), .base(base),
        .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
        .addr_out(addr_out), .addr_vld(addr_vld), .addr_ack(addr_ack)
    );

    always #5 ap_clk = ~ap_clk;

    int cyc = 0;
    always @(posedge ap_clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [15:0] addr;
        int          cyc;   // -1 when acceptance cycle is not predicted
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];
    int   checks = 0;
    int   failures = 0;
    int   ack_mode = 0;      // 0: always ack, 1: random, 2: stall at stall_addr
    int   stall_left = 0;
    logic [15:0] stall_addr = 16'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event required=none", name);
    endtask

    // Reference model: every address of the job in row-major order, plain arithmetic.
    task automatic push_job(input int s, input int r, input int c, input int b,
                            input bit timed, input int t0,
                            input int stall_idx, input int stall_len);
        exp_t e;
        int   idx;
        idx = 0;
        if (r == 0 || c == 0) begin
            done_q.push_back(timed ? t0 + 1 : -1);
            return;
        end
        for (int rr = 0; rr < r; rr++) begin
            for (int cc = 0; cc < c; cc++) begin
                e.addr = 16'(b + s * rr + cc);
                e.cyc  = timed ? (t0 + 2 + rr * (c + 1) + cc + ((idx >= stall_idx) ? stall_len : 0)) : -1;
                exp_q.push_back(e);
                idx++;
            end
        end
        done_q.push_back(timed ? (t0 + r * (c + 1) + 1 + stall_len) : -1);
    endtask

    // Called at posedge+1 while idle; returns at posedge+1 of cycle 1.
    task automatic launch(input int s, input int r, input int c, input int b,
                          input bit timed, input int stall_idx, input int stall_len);
        chk("start_when_idle", {31'd0, ap_idle}, 32'd1);
        stride   = SW'(s);
        rows     = RW'(r);
        cols     = SW'(c);
        base     = AW'(b);
        ap_start = 1'b1;
        push_job(s, r, c, b, timed, cyc, stall_idx, stall_len);
        @(posedge ap_clk);
        #1;
        ap_start = 1'b0;
        stride   = SW'($urandom);
        rows     = RW'($urandom);
        cols     = SW'($urandom);
        base     = AW'($urandom);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(posedge ap_clk);
            #1;
            n++;
        end while (!(ap_idle === 1'b1 && exp_q.size() == 0 && done_q.size() == 0) && n < 3000);
        if (n >= 3000) begin
            $display("FAIL %s_timeout actual=busy required=idle", name);
            checks++;
            failures++;
            exp_q.delete();
            done_q.delete();
        end
    endtask

    // Acknowledge driver.
    initial begin
        addr_ack = 1'b1;
        forever begin
            @(posedge ap_clk);
            #1;
            case (ack_mode)
                0: addr_ack = 1'b1;
                1: addr_ack = ($urandom_range(0, 3) != 0);
                2: begin
                    if (stall_left > 0 && addr_vld === 1'b1 && addr_out == stall_addr) begin
                        addr_ack = 1'b0;
                        stall_left--;
                    end else begin
                        addr_ack = 1'b1;
                    end
                end
                default: addr_ack = 1'b1;
            endcase
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an address or done.
    initial begin
        exp_t e;
        int   d;
        forever begin
            @(negedge ap_clk);
            if (addr_vld === 1'b1) begin
                if (exp_q.size() == 0) begin
                    flag("unexpected_addr");
                end else if (addr_ack) begin
                    e = exp_q.pop_front();
                    chk("addr_value", {16'd0, addr_out}, {16'd0, e.addr});
                    if (e.cyc >= 0) chk("addr_cycle", cyc, e.cyc);
                end else begin
                    chk("addr_stall_hold", {16'd0, addr_out}, {16'd0, exp_q[0].addr});
                end
            end
            if (ap_done === 1'b1) begin
                if (done_q.size() == 0) begin
                    flag("unexpected_done");
                end else begin
                    d = done_q.pop_front();
                    chk("done_all_addrs_seen", exp_q.size(), 32'd0);
                    if (d >= 0) chk("done_cycle", cyc, d);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  found;
        int  i;
        int  s, r, c, b;

        repeat (3) @(posedge ap_clk);
        #1;
        chk("rst_idle", {31'd0, ap_idle}, 32'd1);
        chk("rst_done", {31'd0, ap_done}, 32'd0);
        chk("rst_vld", {31'd0, addr_vld}, 32'd0);
        chk("rst_addr", {16'd0, addr_out}, 32'd0);
        chk("rst_din0", {17'd0, mul_din0}, 32'd0);
        chk("rst_din1", {27'd0, mul_din1}, 32'd0);
        ap_rst = 1'b0;

        // Basic sequence, fully timed.
        ack_mode = 0;
        launch(10, 3, 4, 100, 1'b1, BIG, 0);
        wait_idle("basic");

        // Product truncation, back-to-back.
        launch(32'h7FFF, 4, 1, 0, 1'b1, BIG, 0);
        wait_idle("trunc");

        // Address wrap.
        launch(32'h7FFF, 2, 2, 32'hFFF0, 1'b1, BIG, 0);
        wait_idle("wrap");

        // Backpressure: 5 stalled cycles on address 111 (index 5 of the job).
        ack_mode   = 2;
        stall_addr = 16'd111;
        stall_left = 5;
        launch(10, 3, 4, 100, 1'b1, 5, 5);
        wait_idle("stall");
        ack_mode = 0;

        // Zero-size jobs.
        launch(5, 0, 4, 200, 1'b1, BIG, 0);
        chk("zrows_idle_low", {31'd0, ap_idle}, 32'd0);
        chk("zrows_no_vld", {31'd0, addr_vld}, 32'd0);
        @(posedge ap_clk);
        #1;
        chk("zrows_idle_back", {31'd0, ap_idle}, 32'd1);
        chk("zrows_done_seen", done_q.size(), 32'd0);

        launch(5, 3, 0, 200, 1'b1, BIG, 0);
        chk("zcols_idle_low", {31'd0, ap_idle}, 32'd0);
        chk("zcols_no_vld", {31'd0, addr_vld}, 32'd0);
        @(posedge ap_clk);
        #1;
        chk("zcols_idle_back", {31'd0, ap_idle}, 32'd1);
        chk("zcols_done_seen", done_q.size(), 32'd0);

        // Start pulse during EMIT must be ignored.
        launch(10, 3, 4, 100, 1'b1, BIG, 0);
        repeat (4) begin
            @(posedge ap_clk);
            #1;
        end
        chk("ign_in_emit", {31'd0, addr_vld}, 32'd1);
        stride   = 15'd3;
        rows     = 5'd1;
        cols     = 15'd1;
        base     = 16'd0;
        ap_start = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_start = 1'b0;
        wait_idle("ignstart");

        // Mid-job reset at address 112.
        launch(10, 3, 4, 100, 1'b1, BIG, 0);
        found = 0;
        i = 0;
        while (found == 0 && i < 40) begin
            if (addr_vld === 1'b1 && addr_out == 16'd112) begin
                found = 1;
            end else begin
                @(posedge ap_clk);
                #1;
                i++;
            end
        end
        chk("rst_reach_112", found, 32'd1);
        ap_rst = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        exp_q.delete();
        done_q.delete();
        chk("midrst_vld", {31'd0, addr_vld}, 32'd0);
        chk("midrst_idle", {31'd0, ap_idle}, 32'd1);
        repeat (20) begin
            @(posedge ap_clk);
            #1;
            chk("midrst_no_done", {31'd0, ap_done}, 32'd0);
        end

        // Randomized jobs with random acknowledge.
        ack_mode = 1;
        for (int j = 0; j < 25; j++) begin
            s = int'($urandom_range(0, 32767));
            b = int'($urandom_range(0, 65535));
            if ($urandom_range(0, 4) == 0) begin
                r = int'($urandom_range(0, 31));
                c = int'($urandom_range(0, 2));
            end else begin
                r = int'($urandom_range(0, 5));
                c = int'($urandom_range(0, 8));
            end
            launch(s, r, c, b, 1'b0, BIG, 0);
            wait_idle("random");
        end
        ack_mode = 0;

        repeat (3) @(posedge ap_clk);
        #1;
        chk("end_addr_q_empty", exp_q.size(), 32'd0);
        chk("end_done_q_empty", done_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
